// File: rtl/mips_disasm.sv
// Debug-only MIPS disassembler: registers a 32-character ASCII rendering
// of instr/pc each cycle for waveform viewing. Drives no datapath logic.
module mips_disasm (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc,
    input  logic [31:0]  instr,
    input  logic         reg_name,
    output logic [255:0] asm
);

    // Operand layouts; the mnemonic is chosen separately
    localparam logic [3:0] F_BARE = 4'd0;
    localparam logic [3:0] F_R3   = 4'd1;
    localparam logic [3:0] F_SH   = 4'd2;
    localparam logic [3:0] F_SHV  = 4'd3;
    localparam logic [3:0] F_MD   = 4'd4;
    localparam logic [3:0] F_RD   = 4'd5;
    localparam logic [3:0] F_RS   = 4'd6;
    localparam logic [3:0] F_JALR = 4'd7;
    localparam logic [3:0] F_IMM  = 4'd8;
    localparam logic [3:0] F_LUI  = 4'd9;
    localparam logic [3:0] F_MEM  = 4'd10;
    localparam logic [3:0] F_BR2  = 4'd11;
    localparam logic [3:0] F_BR1  = 4'd12;
    localparam logic [3:0] F_J    = 4'd13;
    localparam logic [3:0] F_COP0 = 4'd14;
    localparam logic [3:0] F_WORD = 4'd15;

    // Text under construction plus the next free character slot
    typedef struct packed {
        logic [255:0] t;
        logic [5:0]   p;
    } sbuf_t;

    function automatic sbuf_t ap_ch(input sbuf_t b, input logic [7:0] c);
        sbuf_t r;
        r = b;
        if (b.p < 6'd32) begin
            r.t[8*(31-int'(b.p)) +: 8] = c;
        end
        r.p = b.p + 6'd1;
        return r;
    endfunction

    // Right-aligned literal; zero bytes are skipped
    function automatic sbuf_t ap_str(input sbuf_t b, input logic [63:0] s);
        sbuf_t r;
        r = b;
        for (int i = 7; i >= 0; i--) begin
            if (s[8*i +: 8] != 8'h00) begin
                r = ap_ch(r, s[8*i +: 8]);
            end
        end
        return r;
    endfunction

    function automatic sbuf_t ap_dec(input sbuf_t b, input logic [4:0] v);
        sbuf_t r;
        r = b;
        if (v >= 5'd10) begin
            r = ap_ch(r, 8'h30 + {3'b000, v / 5'd10});
        end
        r = ap_ch(r, 8'h30 + {3'b000, v % 5'd10});
        return r;
    endfunction

    function automatic logic [7:0] hx(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
    endfunction

    function automatic sbuf_t ap_hex(input sbuf_t b, input logic [31:0] v,
                                     input int n);
        sbuf_t r;
        r = ap_str(b, 64'("0x"));
        for (int i = 7; i >= 0; i--) begin
            if (i < n) begin
                r = ap_ch(r, hx(v[4*i +: 4]));
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] abi(input logic [4:0] n);
        logic [31:0] s;
        case (n)
            5'd0:  s = 32'("zero");
            5'd1:  s = 32'("at");
            5'd2:  s = 32'("v0");
            5'd3:  s = 32'("v1");
            5'd4:  s = 32'("a0");
            5'd5:  s = 32'("a1");
            5'd6:  s = 32'("a2");
            5'd7:  s = 32'("a3");
            5'd8:  s = 32'("t0");
            5'd9:  s = 32'("t1");
            5'd10: s = 32'("t2");
            5'd11: s = 32'("t3");
            5'd12: s = 32'("t4");
            5'd13: s = 32'("t5");
            5'd14: s = 32'("t6");
            5'd15: s = 32'("t7");
            5'd16: s = 32'("s0");
            5'd17: s = 32'("s1");
            5'd18: s = 32'("s2");
            5'd19: s = 32'("s3");
            5'd20: s = 32'("s4");
            5'd21: s = 32'("s5");
            5'd22: s = 32'("s6");
            5'd23: s = 32'("s7");
            5'd24: s = 32'("t8");
            5'd25: s = 32'("t9");
            5'd26: s = 32'("k0");
            5'd27: s = 32'("k1");
            5'd28: s = 32'("gp");
            5'd29: s = 32'("sp");
            5'd30: s = 32'("fp");
            default: s = 32'("ra");
        endcase
        return s;
    endfunction

    function automatic sbuf_t ap_reg(input sbuf_t b, input logic [4:0] n,
                                     input logic use_abi);
        sbuf_t r;
        r = ap_ch(b, 8'h24);
        if (use_abi) begin
            r = ap_str(r, {32'h0, abi(n)});
        end else begin
            r = ap_dec(r, n);
        end
        return r;
    endfunction

    function automatic sbuf_t ap_sep(input sbuf_t b);
        return ap_str(b, 64'(", "));
    endfunction

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign sh     = instr[10:6];
    assign fn     = instr[5:0];
    assign imm    = instr[15:0];
    assign pc4    = pc + 32'd4;
    assign br_tgt = pc4 + {{14{imm[15]}}, imm, 2'b00};
    assign j_tgt  = {pc4[31:28], instr[25:0], 2'b00};

    logic [63:0] mnem;
    logic [3:0]  fmt;

    // Select mnemonic and operand layout from opcode/funct
    always_comb begin
        mnem = 64'(".word");
        fmt  = F_WORD;
        if (instr == 32'h0) begin
            mnem = 64'("nop");
            fmt  = F_BARE;
        end else begin
            case (op)
                6'h00: begin
                    case (fn)
                        6'h00: begin mnem = 64'("sll");     fmt = F_SH;   end
                        6'h02: begin mnem = 64'("srl");     fmt = F_SH;   end
                        6'h03: begin mnem = 64'("sra");     fmt = F_SH;   end
                        6'h04: begin mnem = 64'("sllv");    fmt = F_SHV;  end
                        6'h06: begin mnem = 64'("srlv");    fmt = F_SHV;  end
                        6'h07: begin mnem = 64'("srav");    fmt = F_SHV;  end
                        6'h08: begin mnem = 64'("jr");      fmt = F_RS;   end
                        6'h09: begin mnem = 64'("jalr");    fmt = F_JALR; end
                        6'h0c: begin mnem = 64'("syscall"); fmt = F_BARE; end
                        6'h10: begin mnem = 64'("mfhi");    fmt = F_RD;   end
                        6'h11: begin mnem = 64'("mthi");    fmt = F_RS;   end
                        6'h12: begin mnem = 64'("mflo");    fmt = F_RD;   end
                        6'h13: begin mnem = 64'("mtlo");    fmt = F_RS;   end
                        6'h18: begin mnem = 64'("mult");    fmt = F_MD;   end
                        6'h19: begin mnem = 64'("multu");   fmt = F_MD;   end
                        6'h1a: begin mnem = 64'("div");     fmt = F_MD;   end
                        6'h1b: begin mnem = 64'("divu");    fmt = F_MD;   end
                        6'h20: begin mnem = 64'("add");     fmt = F_R3;   end
                        6'h21: begin mnem = 64'("addu");    fmt = F_R3;   end
                        6'h22: begin mnem = 64'("sub");     fmt = F_R3;   end
                        6'h23: begin mnem = 64'("subu");    fmt = F_R3;   end
                        6'h24: begin mnem = 64'("and");     fmt = F_R3;   end
                        6'h25: begin mnem = 64'("or");      fmt = F_R3;   end
                        6'h26: begin mnem = 64'("xor");     fmt = F_R3;   end
                        6'h27: begin mnem = 64'("nor");     fmt = F_R3;   end
                        6'h2a: begin mnem = 64'("slt");     fmt = F_R3;   end
                        6'h2b: begin mnem = 64'("sltu");    fmt = F_R3;   end
                        default: ;
                    endcase
                end
                6'h01: begin
                    if (rt == 5'd0) begin
                        mnem = 64'("bltz"); fmt = F_BR1;
                    end else if (rt == 5'd1) begin
                        mnem = 64'("bgez"); fmt = F_BR1;
                    end
                end
                6'h02: begin mnem = 64'("j");     fmt = F_J;   end
                6'h03: begin mnem = 64'("jal");   fmt = F_J;   end
                6'h04: begin mnem = 64'("beq");   fmt = F_BR2; end
                6'h05: begin mnem = 64'("bne");   fmt = F_BR2; end
                6'h06: begin mnem = 64'("blez");  fmt = F_BR1; end
                6'h07: begin mnem = 64'("bgtz");  fmt = F_BR1; end
                6'h08: begin mnem = 64'("addi");  fmt = F_IMM; end
                6'h09: begin mnem = 64'("addiu"); fmt = F_IMM; end
                6'h0a: begin mnem = 64'("slti");  fmt = F_IMM; end
                6'h0b: begin mnem = 64'("sltiu"); fmt = F_IMM; end
                6'h0c: begin mnem = 64'("andi");  fmt = F_IMM; end
                6'h0d: begin mnem = 64'("ori");   fmt = F_IMM; end
                6'h0e: begin mnem = 64'("xori");  fmt = F_IMM; end
                6'h0f: begin mnem = 64'("lui");   fmt = F_LUI; end
                6'h10: begin
                    if (rs == 5'h00) begin
                        mnem = 64'("mfc0"); fmt = F_COP0;
                    end else if (rs == 5'h04) begin
                        mnem = 64'("mtc0"); fmt = F_COP0;
                    end else if (rs == 5'h10 && fn == 6'h18) begin
                        mnem = 64'("eret"); fmt = F_BARE;
                    end
                end
                6'h20: begin mnem = 64'("lb");  fmt = F_MEM; end
                6'h21: begin mnem = 64'("lh");  fmt = F_MEM; end
                6'h23: begin mnem = 64'("lw");  fmt = F_MEM; end
                6'h24: begin mnem = 64'("lbu"); fmt = F_MEM; end
                6'h25: begin mnem = 64'("lhu"); fmt = F_MEM; end
                6'h28: begin mnem = 64'("sb");  fmt = F_MEM; end
                6'h29: begin mnem = 64'("sh");  fmt = F_MEM; end
                6'h2b: begin mnem = 64'("sw");  fmt = F_MEM; end
                default: ;
            endcase
        end
    end

    sbuf_t       s;
    logic [255:0] nxt;

    // Render mnemonic and operands into a space-padded 32-char line
    always_comb begin
        s.t = {32{8'h20}};
        s.p = 6'd0;
        s = ap_str(s, mnem);
        if (fmt != F_BARE) begin
            s = ap_ch(s, 8'h20);
        end
        case (fmt)
            F_R3: begin
                s = ap_reg(s, rd, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rs, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rt, reg_name);
            end
            F_SH: begin
                s = ap_reg(s, rd, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rt, reg_name);
                s = ap_sep(s);
                s = ap_dec(s, sh);
            end
            F_SHV: begin
                s = ap_reg(s, rd, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rt, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rs, reg_name);
            end
            F_MD: begin
                s = ap_reg(s, rs, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rt, reg_name);
            end
            F_RD: s = ap_reg(s, rd, reg_name);
            F_RS: s = ap_reg(s, rs, reg_name);
            F_JALR: begin
                s = ap_reg(s, rd, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rs, reg_name);
            end
            F_IMM: begin
                s = ap_reg(s, rt, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rs, reg_name);
                s = ap_sep(s);
                s = ap_hex(s, {16'h0, imm}, 4);
            end
            F_LUI: begin
                s = ap_reg(s, rt, reg_name);
                s = ap_sep(s);
                s = ap_hex(s, {16'h0, imm}, 4);
            end
            F_MEM: begin
                s = ap_reg(s, rt, reg_name);
                s = ap_sep(s);
                s = ap_hex(s, {16'h0, imm}, 4);
                s = ap_ch(s, 8'h28);
                s = ap_reg(s, rs, reg_name);
                s = ap_ch(s, 8'h29);
            end
            F_BR2: begin
                s = ap_reg(s, rs, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rt, reg_name);
                s = ap_sep(s);
                s = ap_hex(s, br_tgt, 8);
            end
            F_BR1: begin
                s = ap_reg(s, rs, reg_name);
                s = ap_sep(s);
                s = ap_hex(s, br_tgt, 8);
            end
            F_J: s = ap_hex(s, j_tgt, 8);
            F_COP0: begin
                s = ap_reg(s, rt, reg_name);
                s = ap_sep(s);
                s = ap_reg(s, rd, 1'b0);
            end
            F_WORD: s = ap_hex(s, instr, 8);
            default: ;
        endcase
        nxt = s.t;
    end

    // Output register; reset blanks the line
    always_ff @(posedge clk) begin
        if (reset) begin
            asm <= {32{8'h20}};
        end else begin
            asm <= nxt;
        end
    end

endmodule

// File: tb/tb_mips_disasm.sv
// Directed-vector bench for mips_disasm: decode table plus latency
// and reset-priority sequences.
module tb_mips_disasm;

    logic         clk;
    logic         reset;
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic         reg_name;
    logic [255:0] asm;

    int errors = 0;
    int checks = 0;

    mips_disasm dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .instr    (instr),
        .reg_name (reg_name),
        .asm      (asm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rn;
        string       txt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [255:0] pad(input string str);
        logic [255:0] r;
        r = {32{8'h20}};
        for (int i = 0; i < str.len() && i < 32; i++) begin
            r[8*(31-i) +: 8] = str.getc(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] exp);
        checks++;
        if (asm !== exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, asm, exp);
        end
    endtask

    task automatic add(input logic [31:0] p, input logic [31:0] i,
                       input logic rn, input string t);
        vec_t v;
        v.pc = p;
        v.instr = i;
        v.rn = rn;
        v.txt = t;
        vecs.push_back(v);
    endtask

    initial begin
        add(32'h0, 32'h00000000, 1'b0, "nop");
        add(32'h0, 32'h00221821, 1'b0, "addu $3, $1, $2");
        add(32'h0, 32'h00221821, 1'b1, "addu $v1, $at, $v0");
        add(32'h0, 32'h34081234, 1'b0, "ori $8, $0, 0x1234");
        add(32'h0, 32'h8FA90004, 1'b0, "lw $9, 0x0004($29)");
        add(32'h3000, 32'h1022FFFF, 1'b0, "beq $1, $2, 0x00003000");
        add(32'h3000, 32'h08000C10, 1'b0, "j 0x00003040");
        add(32'h0, 32'hFC000000, 1'b0, ".word 0xfc000000");
        add(32'h0, 32'h00031140, 1'b0, "sll $2, $3, 5");
        add(32'h0, 32'h001FFFC3, 1'b0, "sra $31, $31, 31");
        add(32'h0, 32'h001FFFC3, 1'b1, "sra $ra, $ra, 31");
        add(32'h0, 32'h03E00008, 1'b1, "jr $ra");
        add(32'hF0000000, 32'h0C000001, 1'b0, "jal 0xf0000004");
        add(32'hFFFFFFFC, 32'h08000000, 1'b0, "j 0x00000000");
        add(32'hFFFFFFFC, 32'h14000001, 1'b0, "bne $0, $0, 0x00000004");
        add(32'h100, 32'h0481FFFE, 1'b1, "bgez $a0, 0x000000fc");
        add(32'h0, 32'h40086000, 1'b1, "mfc0 $t0, $12");
        add(32'h0, 32'h42000018, 1'b0, "eret");
        add(32'h0, 32'h0000000C, 1'b0, "syscall");
        add(32'h0, 32'h00000001, 1'b0, ".word 0x00000001");
        add(32'h0, 32'h04020000, 1'b0, ".word 0x04020000");
        add(32'h0, 32'h00850018, 1'b1, "mult $a0, $a1");
        add(32'h0, 32'hAFBFFFFC, 1'b1, "sw $ra, 0xfffc($sp)");
        add(32'h0, 32'h3C1BABCD, 1'b0, "lui $27, 0xabcd");
        add(32'h0, 32'h018B5004, 1'b1, "sllv $t2, $t3, $t4");
        add(32'h0, 32'h0120F809, 1'b0, "jalr $31, $9");
        add(32'h0, 32'h00008010, 1'b1, "mfhi $s0");
        add(32'h0, 32'h0399F021, 1'b1, "addu $fp, $gp, $t9");
        add(32'h0, 32'h2B57FFFF, 1'b1, "slti $s7, $k0, 0xffff");
        add(32'h0, 32'h0000000C, 1'b1, "syscall");

        reset = 1'b1;
        pc = 32'h0;
        instr = 32'h00221821;
        reg_name = 1'b0;
        @(posedge clk);
        #1;
        check("reset_blank", {32{8'h20}});

        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            pc = vecs[i].pc;
            instr = vecs[i].instr;
            reg_name = vecs[i].rn;
            @(posedge clk);
            #1;
            check(vecs[i].txt, pad(vecs[i].txt));
        end

        // Mid-cycle input change must not show until the next edge
        @(negedge clk);
        pc = 32'h0;
        instr = 32'h34081234;
        reg_name = 1'b0;
        @(posedge clk);
        #1;
        check("lat_first", pad("ori $8, $0, 0x1234"));
        instr = 32'hFC000000;
        #3;
        check("lat_hold", pad("ori $8, $0, 0x1234"));
        @(posedge clk);
        #1;
        check("lat_next", pad(".word 0xfc000000"));

        // Reset asserted alongside a valid instruction wins
        @(negedge clk);
        reset = 1'b1;
        instr = 32'h00221821;
        @(posedge clk);
        #1;
        check("rst_prio", {32{8'h20}});
        reset = 1'b0;
        #2;
        check("rst_hold", {32{8'h20}});
        @(posedge clk);
        #1;
        check("rst_release", pad("addu $3, $1, $2"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
